// File: rtl/imem_wait.sv
// Instruction memory with a registered, handshaked fetch port, programmable wait
// states and an independent program-load write port. Faulting fetches (misaligned
// or beyond DEPTH) return FILL_WORD with rsp_err set after the same latency.
module imem_wait #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                LATENCY   = 1,
  parameter logic [DATA_W-1:0] FILL_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IW-1:0]   idx;
  logic            fault;
  logic            accept;
  logic            load;
  logic            req_fault;
  logic            wr_fault;

  // Storage holds word XOR FILL_WORD, so zero power-up content reads back as
  // FILL_WORD and reset never has to touch the array.
  logic [DATA_W-1:0] mem [DEPTH];

  assign req_fault = (|req_addr[1:0]) || (|req_addr[ADDR_W-1:IW+2]);
  assign wr_fault  = (|wr_addr[1:0])  || (|wr_addr[ADDR_W-1:IW+2]);

  // Program-load writes land on every edge regardless of fetch state; bad addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_fault) begin
      mem[wr_addr[IW+1:2]] <= wr_data ^ FILL_WORD;
    end
  end

  // Next-state, wait countdown and handshake outputs.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    load      = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          load    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request and response registers; the read samples the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      fault    <= 1'b0;
      rsp_data <= FILL_WORD;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        idx   <= req_addr[IW+1:2];
        fault <= req_fault;
      end
      if (load) begin
        rsp_err  <= fault;
        rsp_data <= fault ? FILL_WORD : (mem[idx] ^ FILL_WORD);
      end
    end
  end

endmodule

// File: tb/tb_imem_wait.sv
// Bench for imem_wait: two instances (LATENCY 1 and 4) driven by directed steps and
// random traffic, checked against a word-array reference of the memory contents.
module tb_imem_wait;

  localparam int          LAT0 = 1;
  localparam int          LAT1 = 4;
  localparam logic [31:0] FILL = 32'h00000013;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        wr_en     [2];
  logic [31:0] wr_addr   [2];
  logic [31:0] wr_data   [2];
  logic        busy      [2];

  logic [31:0] mm [2][256];
  int checks = 0;
  int errors = 0;

  imem_wait #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .LATENCY(LAT0), .FILL_WORD(FILL)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .busy(busy[0]));

  imem_wait #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .LATENCY(LAT1), .FILL_WORD(FILL)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
  endfunction

  function automatic void model_write(input int d, input logic [31:0] a, input logic [31:0] v);
    if (!is_fault(a)) mm[d][a[9:2]] = v;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] w;
    r = $urandom_range(0, 9);
    w = 32'($urandom_range(0, 15)) << 2;
    if (r == 0) return w | 32'($urandom_range(1, 3));
    if (r == 1) return 32'($urandom_range(256, 4095)) << 2;
    return w;
  endfunction

  // Called at a negedge; write occupies exactly one clock edge.
  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] v);
    wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v;
    @(negedge clk);
    wr_en[d] = 1'b0;
    model_write(d, a, v);
  endtask

  // Full fetch transaction from an idle negedge. wk (1..lat) places an extra write on edge N+wk.
  task automatic fetch(input int d, input logic [31:0] a, input int wk,
                       input logic [31:0] wa, input logic [31:0] wdat, input int bp);
    int          lat;
    logic        flt;
    logic [31:0] exp_d;
    lat   = (d == 0) ? LAT0 : LAT1;
    flt   = is_fault(a);
    exp_d = FILL;
    check1("idle_ready", req_ready[d], 1'b1);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    rsp_ready[d] = (bp == 0);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    check1("wait_busy", busy[d], 1'b1);
    check1("wait_ready", req_ready[d], 1'b0);
    for (int j = 1; j <= lat; j++) begin
      if (j == wk) begin
        wr_en[d] = 1'b1; wr_addr[d] = wa; wr_data[d] = wdat;
      end
      @(negedge clk);
      wr_en[d] = 1'b0;
      if (j == lat && !flt) exp_d = mm[d][a[9:2]];
      if (j == wk) model_write(d, wa, wdat);
      check1("rsp_valid_timing", rsp_valid[d], j == lat);
    end
    check32("rsp_data", rsp_data[d], exp_d);
    check1("rsp_err", rsp_err[d], flt);
    for (int b = 0; b < bp; b++) begin
      req_valid[d] = 1'b1;
      req_addr[d]  = $urandom;
      @(negedge clk);
      check1("bp_valid", rsp_valid[d], 1'b1);
      check32("bp_data", rsp_data[d], exp_d);
      check1("bp_err", rsp_err[d], flt);
      check1("bp_ready", req_ready[d], 1'b0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    check1("post_valid", rsp_valid[d], 1'b0);
    check1("post_ready", req_ready[d], 1'b1);
    check1("post_busy", busy[d], 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mm[d][i] = FILL;
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; rsp_ready[d] = 1'b0;
      wr_en[d] = 1'b0; wr_addr[d] = '0; wr_data[d] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check1("rst_ready", req_ready[d], 1'b1);
      check1("rst_valid", rsp_valid[d], 1'b0);
      check1("rst_err", rsp_err[d], 1'b0);
      check32("rst_data", rsp_data[d], FILL);
      check1("rst_busy", busy[d], 1'b0);
      rst[d] = 1'b0;
    end
    @(negedge clk);

    // Program load then fetch at LATENCY 1
    do_write(0, 32'h0, 32'h00000013);
    do_write(0, 32'h4, 32'h00000013);
    do_write(0, 32'h8, 32'h03400093);
    fetch(0, 32'h8, 0, 32'h0, 32'h0, 0);
    check32("prog_word", mm[0][2], 32'h03400093);

    // LATENCY 4 fetch of a fill word, and a write to a latched word inside WAIT
    do_write(1, 32'h8, 32'h03400093);
    fetch(1, 32'h4, 0, 32'h0, 32'h0, 0);
    fetch(1, 32'h10, 2, 32'h10, 32'hCAFEF00D, 0);

    // Backpressure with ignored requests
    fetch(0, 32'h8, 0, 32'h0, 32'h0, 5);

    // Faults: misaligned and out-of-range fetches, dropped writes
    fetch(0, 32'h2, 0, 32'h0, 32'h0, 0);
    fetch(0, 32'h400, 0, 32'h0, 32'h0, 0);
    do_write(0, 32'h400, 32'h11111111);
    do_write(0, 32'h2, 32'h22222222);
    fetch(0, 32'h0, 0, 32'h0, 32'h0, 0);
    fetch(1, 32'h400, 0, 32'h0, 32'h0, 2);

    // Collision on the read edge returns the old word; refetch sees the new one
    fetch(0, 32'h8, 1, 32'h8, 32'hDEADBEEF, 0);
    fetch(0, 32'h8, 0, 32'h0, 32'h0, 0);
    fetch(1, 32'h8, 4, 32'h8, 32'h12345678, 1);
    fetch(1, 32'h8, 0, 32'h0, 32'h0, 0);

    // Reset while waiting drops the request and keeps memory
    req_valid[1] = 1'b1; req_addr[1] = 32'h8;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    check1("midrst_ready", req_ready[1], 1'b1);
    check1("midrst_valid", rsp_valid[1], 1'b0);
    check1("midrst_busy", busy[1], 1'b0);
    check32("midrst_data", rsp_data[1], FILL);
    @(negedge clk);
    rst[1] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check1("after_rst_valid", rsp_valid[1], 1'b0);
    end
    fetch(1, 32'h8, 0, 32'h0, 32'h0, 0);

    // Random traffic on both instances
    for (int n = 0; n < 80; n++) begin
      int          d;
      int          lat;
      logic [31:0] a;
      d   = int'($urandom_range(0, 1));
      lat = (d == 0) ? LAT0 : LAT1;
      a   = rand_addr();
      if ($urandom_range(0, 2) == 0) begin
        do_write(d, a, $urandom);
      end else begin
        logic [31:0] wa;
        wa = ($urandom_range(0, 1) == 0) ? a : rand_addr();
        fetch(d, a, int'($urandom_range(0, lat)), wa, $urandom, int'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
